rocc_cmd_resp_queue: RTL and testbench

- Decoupling stage between the core's RoCC port and a RoCC accelerator (e.g. the accumulator black box).
- Buffers commands in a CMD_DEPTH FIFO and registers accelerator responses before returning them to the core.
- Counts commands with xd=1 still awaiting a response, and drives core-visible busy from FIFO occupancy, that count and the response register.

---
 rtl/rocc_cmd_resp_queue_pkg.sv | 32 +++
 rtl/rocc_cmd_resp_queue_if.sv | 30 +++
 rtl/rocc_cmd_fifo.sv | 59 +++++
 rtl/rocc_cmd_resp_queue.sv | 155 +++++++++++++++
 tb/tb_rocc_cmd_resp_queue.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/rocc_cmd_resp_queue_pkg.sv
// Shared types for the RoCC command/response queue: instruction, command and response records.
// The struct data width is fixed here; the top's XLEN parameter must match RoccXlen.
package rocc_queue_pkg;

    localparam int unsigned RoccXlen = 64;
    localparam int unsigned InstW    = 32;
    localparam int unsigned RegW     = 5;

    // Field order matches the RoCC instruction word, MSB first.
    typedef struct packed {
        logic [6:0]      funct;
        logic [RegW-1:0] rs2;
        logic [RegW-1:0] rs1;
        logic            xd;
        logic            xs1;
        logic            xs2;
        logic [RegW-1:0] rd;
        logic [6:0]      opcode;
    } rocc_inst_t;

    typedef struct packed {
        rocc_inst_t          inst;
        logic [RoccXlen-1:0] rs1;
        logic [RoccXlen-1:0] rs2;
    } rocc_cmd_t;

    typedef struct packed {
        logic [RegW-1:0]     rd;
        logic [RoccXlen-1:0] data;
    } rocc_resp_t;

endpackage

// File: rtl/rocc_cmd_resp_queue_if.sv
// RoCC command + response channel pair. The master issues commands and accepts responses;
// the slave accepts commands and returns responses.
interface rocc_cmd_resp_queue_if
    import rocc_queue_pkg::*;
#(
    parameter int unsigned XLEN = RoccXlen
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [InstW-1:0] cmd_inst;
    logic [XLEN-1:0]  cmd_rs1;
    logic [XLEN-1:0]  cmd_rs2;

    logic             resp_valid;
    logic             resp_ready;
    logic [RegW-1:0]  resp_rd;
    logic [XLEN-1:0]  resp_data;

    modport master (
        output cmd_valid, cmd_inst, cmd_rs1, cmd_rs2, resp_ready,
        input  cmd_ready, resp_valid, resp_rd, resp_data
    );

    modport slave (
        input  cmd_valid, cmd_inst, cmd_rs1, cmd_rs2, resp_ready,
        output cmd_ready, resp_valid, resp_rd, resp_data
    );

endinterface

// File: rtl/rocc_cmd_fifo.sv
// Synchronous FIFO of RoCC commands with occupancy count; head is read combinationally.
// Pushes while full and pops while empty are ignored.
module rocc_cmd_fifo
    import rocc_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  rocc_cmd_t   wdata,
    input  logic        pop,
    output rocc_cmd_t   rdata,
    output logic [PtrW:0] count,
    output logic        full,
    output logic        empty
);

    rocc_cmd_t         mem_q [DEPTH];
    logic [PtrW-1:0]   wptr_q;
    logic [PtrW-1:0]   rptr_q;
    logic [PtrW:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == (PtrW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q];

    // Storage is cleared too so the head data outputs read as zero out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PtrW+1)'(1);
                2'b01:   count_q <= count_q - (PtrW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rocc_cmd_resp_queue.sv
// Decoupling queue between a core RoCC port and an accelerator: command FIFO, outstanding
// xd=1 counter and a response pipe register. Optional macro ROCC_CMD_BYPASS_EN adds an
// empty-FIFO zero-latency command bypass.
module rocc_cmd_resp_queue
    import rocc_queue_pkg::*;
#(
    parameter int unsigned XLEN            = RoccXlen,
    parameter int unsigned CMD_DEPTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    rocc_cmd_resp_queue_if.slave  core,
    rocc_cmd_resp_queue_if.master acc,
    output logic                  busy,
    output logic                  resp_unexpected
);

    localparam int unsigned PtrW = $clog2(CMD_DEPTH);
    localparam int unsigned OutW = $clog2(MAX_OUTSTANDING) + 1;

    rocc_inst_t      core_inst;
    rocc_cmd_t       cmd_in;
    rocc_cmd_t       fifo_head;
    logic [PtrW:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            cmd_ready;
    logic            core_fire;

    logic [OutW-1:0] outstanding_q;
    logic            unexpected_q;
    logic            out_inc;
    logic            out_dec;

    logic            resp_valid_q;
    rocc_resp_t      resp_q;
    logic            acc_resp_ready;
    logic            resp_load;

    // ---------------- command path ----------------
    assign core_inst  = rocc_inst_t'(core.cmd_inst);
    assign cmd_ready  = !fifo_full && (outstanding_q < OutW'(MAX_OUTSTANDING));
    assign core_fire  = core.cmd_valid && cmd_ready;
    assign core.cmd_ready = cmd_ready;

    always_comb begin
        cmd_in      = '0;
        cmd_in.inst = core_inst;
        cmd_in.rs1  = core.cmd_rs1;
        cmd_in.rs2  = core.cmd_rs2;
    end

`ifdef ROCC_CMD_BYPASS_EN
    logic bypass_fire;

    // A command that leaves through the bypass in its arrival cycle never occupies the FIFO.
    assign bypass_fire = fifo_empty && core_fire && acc.cmd_ready;
    assign fifo_push   = core_fire && !bypass_fire;

    always_comb begin
        acc.cmd_valid = 1'b0;
        acc.cmd_inst  = '0;
        acc.cmd_rs1   = '0;
        acc.cmd_rs2   = '0;
        if (fifo_empty) begin
            acc.cmd_valid = core_fire;
            acc.cmd_inst  = cmd_in.inst;
            acc.cmd_rs1   = cmd_in.rs1;
            acc.cmd_rs2   = cmd_in.rs2;
        end else begin
            acc.cmd_valid = 1'b1;
            acc.cmd_inst  = fifo_head.inst;
            acc.cmd_rs1   = fifo_head.rs1;
            acc.cmd_rs2   = fifo_head.rs2;
        end
    end
`else
    assign fifo_push = core_fire;

    always_comb begin
        acc.cmd_valid = !fifo_empty;
        acc.cmd_inst  = fifo_head.inst;
        acc.cmd_rs1   = fifo_head.rs1;
        acc.cmd_rs2   = fifo_head.rs2;
    end
`endif

    rocc_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .wdata (cmd_in),
        .pop   (acc.cmd_ready),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------- outstanding counter ----------------
    assign out_inc = core_fire && core_inst.xd;
    assign out_dec = resp_valid_q && core.resp_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            outstanding_q <= '0;
            unexpected_q  <= 1'b0;
        end else begin
            unexpected_q <= 1'b0;
            case ({out_inc, out_dec})
                2'b10: outstanding_q <= outstanding_q + OutW'(1);
                2'b01: begin
                    // A response nobody asked for: hold at zero and flag it.
                    if (outstanding_q == '0) begin
                        unexpected_q <= 1'b1;
                    end else begin
                        outstanding_q <= outstanding_q - OutW'(1);
                    end
                end
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign resp_unexpected = unexpected_q;

    // ---------------- response pipe register ----------------
    assign acc_resp_ready = !resp_valid_q || core.resp_ready;
    assign resp_load      = acc.resp_valid && acc_resp_ready;
    assign acc.resp_ready = acc_resp_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
        end else if (resp_load) begin
            resp_valid_q <= 1'b1;
            resp_q.rd    <= acc.resp_rd;
            resp_q.data  <= acc.resp_data;
        end else if (core.resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign core.resp_valid = resp_valid_q;
    assign core.resp_rd    = resp_q.rd;
    assign core.resp_data  = resp_q.data;

    assign busy = (fifo_count != '0) || (outstanding_q != '0) || resp_valid_q;

endmodule

// File: tb/tb_rocc_cmd_resp_queue.sv
// Directed bench for rocc_cmd_resp_queue: a cycle table for the single-command round trip and
// response-path corners, then hand sequences for FIFO-full, outstanding limit, reset and bypass.
module tb_rocc_cmd_resp_queue;
    import rocc_queue_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic resp_unexpected;

    rocc_cmd_resp_queue_if #(.XLEN(64)) core_if ();
    rocc_cmd_resp_queue_if #(.XLEN(64)) acc_if ();

    rocc_cmd_resp_queue #(
        .XLEN            (64),
        .CMD_DEPTH       (4),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .core            (core_if),
        .acc             (acc_if),
        .busy            (busy),
        .resp_unexpected (resp_unexpected)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] mk_inst(input logic xd, input logic [4:0] rd);
        rocc_inst_t i;
        i        = '0;
        i.funct  = 7'd1;
        i.xd     = xd;
        i.xs1    = 1'b1;
        i.xs2    = 1'b1;
        i.rd     = rd;
        i.opcode = 7'h0b;
        return i;
    endfunction

    task automatic drive(input logic cv, input logic xd, input logic [4:0] rd,
                         input logic [7:0] rs1, input logic ar, input logic rv,
                         input logic [7:0] rdata, input logic cr);
        core_if.cmd_valid  = cv;
        core_if.cmd_inst   = mk_inst(xd, rd);
        core_if.cmd_rs1    = 64'(rs1);
        core_if.cmd_rs2    = 64'(rs1) + 64'd1;
        acc_if.cmd_ready   = ar;
        acc_if.resp_valid  = rv;
        acc_if.resp_rd     = rd;
        acc_if.resp_data   = 64'(rdata);
        core_if.resp_ready = cr;
    endtask

    typedef struct {
        logic       cv;
        logic       xd;
        logic [4:0] rd;
        logic [7:0] rs1;
        logic       ar;
        logic       rv;
        logic [7:0] rdata;
        logic       cr;
        logic       e_cready;
        logic       e_avalid;
        logic [7:0] e_ars1;
        logic       e_arr;
        logic       e_rvalid;
        logic [7:0] e_rdata;
        logic       e_busy;
        logic       e_unexp;
    } vec_t;

    vec_t vecs [14];

    initial begin
        // cv xd rd rs1  ar rv rdata cr | cready avalid ars1 arr rvalid rdata busy unexp
        vecs[0]  = '{0, 0, 0, 0,   0, 0, 0,     0,   1, 0, 0, 1, 0, 0,     0, 0};
        vecs[1]  = '{1, 1, 5, 3,   1, 0, 0,     0,   1, 0, 0, 1, 0, 0,     0, 0};
        vecs[2]  = '{0, 0, 0, 0,   1, 0, 0,     0,   1, 1, 3, 1, 0, 0,     1, 0};
        vecs[3]  = '{0, 0, 5, 0,   0, 1, 7,     0,   1, 0, 0, 1, 0, 0,     1, 0};
        vecs[4]  = '{0, 0, 0, 0,   0, 0, 0,     0,   1, 0, 0, 0, 1, 7,     1, 0};
        vecs[5]  = '{0, 0, 0, 0,   0, 0, 0,     1,   1, 0, 0, 1, 1, 7,     1, 0};
        vecs[6]  = '{0, 0, 0, 0,   0, 0, 0,     0,   1, 0, 0, 1, 0, 0,     0, 0};
        vecs[7]  = '{0, 0, 0, 0,   0, 1, 'h11,  1,   1, 0, 0, 1, 0, 0,     0, 0};
        vecs[8]  = '{0, 0, 0, 0,   0, 1, 'h22,  1,   1, 0, 0, 1, 1, 'h11,  1, 0};
        vecs[9]  = '{0, 0, 0, 0,   0, 1, 'h33,  0,   1, 0, 0, 0, 1, 'h22,  1, 1};
        vecs[10] = '{0, 0, 0, 0,   0, 1, 'h33,  0,   1, 0, 0, 0, 1, 'h22,  1, 0};
        vecs[11] = '{0, 0, 0, 0,   0, 0, 0,     1,   1, 0, 0, 1, 1, 'h22,  1, 0};
        vecs[12] = '{0, 0, 0, 0,   0, 0, 0,     0,   1, 0, 0, 1, 0, 0,     0, 1};
        vecs[13] = '{0, 0, 0, 0,   0, 0, 0,     0,   1, 0, 0, 1, 0, 0,     0, 0};

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

`ifndef ROCC_CMD_BYPASS_EN
        // Round trip of one xd=1 command, then response-register throughput and stray responses.
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            drive(vecs[i].cv, vecs[i].xd, vecs[i].rd, vecs[i].rs1, vecs[i].ar, vecs[i].rv,
                  vecs[i].rdata, vecs[i].cr);
            #1;
            check($sformatf("v%0d core_cmd_ready", i), 64'(core_if.cmd_ready),
                  64'(vecs[i].e_cready));
            check($sformatf("v%0d acc_cmd_valid", i), 64'(acc_if.cmd_valid),
                  64'(vecs[i].e_avalid));
            if (vecs[i].e_avalid)
                check($sformatf("v%0d acc_cmd_rs1", i), acc_if.cmd_rs1, 64'(vecs[i].e_ars1));
            check($sformatf("v%0d acc_resp_ready", i), 64'(acc_if.resp_ready),
                  64'(vecs[i].e_arr));
            check($sformatf("v%0d core_resp_valid", i), 64'(core_if.resp_valid),
                  64'(vecs[i].e_rvalid));
            if (vecs[i].e_rvalid)
                check($sformatf("v%0d core_resp_data", i), core_if.resp_data,
                      64'(vecs[i].e_rdata));
            check($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].e_busy));
            check($sformatf("v%0d resp_unexpected", i), 64'(resp_unexpected),
                  64'(vecs[i].e_unexp));
        end
`endif

        // FIFO fill: five xd=0 pushes with the accelerator stalled; the fifth waits for space.
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            drive(1, 0, 1, 8'(10 + i), 0, 0, 0, 0);
            #1;
            check($sformatf("fill%0d core_cmd_ready", i), 64'(core_if.cmd_ready),
                  64'(i < 4));
        end
        for (int j = 0; j < 5; j++) begin
            @(negedge clock);
            if (j >= 2) core_if.cmd_valid = 1'b0;
            acc_if.cmd_ready = 1'b1;
            #1;
            check($sformatf("drain%0d acc_cmd_valid", j), 64'(acc_if.cmd_valid), 64'd1);
            check($sformatf("drain%0d acc_cmd_rs1", j), acc_if.cmd_rs1, 64'(10 + j));
            if (j < 2)
                check($sformatf("drain%0d core_cmd_ready", j), 64'(core_if.cmd_ready),
                      64'(j == 1));
        end
        @(negedge clock);
        #1;
        check("drained acc_cmd_valid", 64'(acc_if.cmd_valid), 64'd0);
        check("drained busy", 64'(busy), 64'd0);

        // Outstanding limit: four xd=1 commands with no responses block further commands.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            drive(1, 1, 2, 8'(20 + i), 1, 0, 0, 0);
            #1;
            check($sformatf("out%0d core_cmd_ready", i), 64'(core_if.cmd_ready), 64'd1);
        end
        @(negedge clock);
        core_if.cmd_valid = 1'b0;
        #1;
        check("limit core_cmd_ready", 64'(core_if.cmd_ready), 64'd0);
        check("limit busy", 64'(busy), 64'd1);
        @(negedge clock);
        #1;
        check("limit empty core_cmd_ready", 64'(core_if.cmd_ready), 64'd0);
        @(negedge clock);
        acc_if.resp_valid = 1'b1;
        acc_if.resp_data  = 64'd99;
        #1;
        check("limit acc_resp_ready", 64'(acc_if.resp_ready), 64'd1);
        @(negedge clock);
        acc_if.resp_valid  = 1'b0;
        core_if.resp_ready = 1'b1;
        #1;
        check("limit core_resp_valid", 64'(core_if.resp_valid), 64'd1);
        check("limit core_resp_data", core_if.resp_data, 64'd99);
        check("limit held core_cmd_ready", 64'(core_if.cmd_ready), 64'd0);
        @(negedge clock);
        core_if.resp_ready = 1'b0;
        #1;
        check("limit released core_cmd_ready", 64'(core_if.cmd_ready), 64'd1);

        // Reset with three commands queued and a response held.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            drive(1, 0, 0, 8'(40 + i), 0, 0, 0, 0);
        end
        @(negedge clock);
        drive(0, 0, 4, 0, 0, 1, 8'h55, 0);
        @(negedge clock);
        acc_if.resp_valid = 1'b0;
        #1;
        check("pre-reset acc_cmd_valid", 64'(acc_if.cmd_valid), 64'd1);
        check("pre-reset core_resp_valid", 64'(core_if.resp_valid), 64'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset acc_cmd_valid", 64'(acc_if.cmd_valid), 64'd0);
        check("reset core_resp_valid", 64'(core_if.resp_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset core_cmd_ready", 64'(core_if.cmd_ready), 64'd1);
        check("reset acc_cmd_rs1", acc_if.cmd_rs1, 64'd0);
        @(negedge clock);
        #1;
        check("post-reset acc_cmd_valid", 64'(acc_if.cmd_valid), 64'd0);
        check("post-reset resp_unexpected", 64'(resp_unexpected), 64'd0);
        check("post-reset busy", 64'(busy), 64'd0);

`ifdef ROCC_CMD_BYPASS_EN
        // Empty FIFO: the command shows up on acc_cmd_* in the same cycle and is not stored.
        @(negedge clock);
        drive(1, 1, 3, 8'h5a, 1, 0, 0, 0);
        #1;
        check("bypass acc_cmd_valid", 64'(acc_if.cmd_valid), 64'd1);
        check("bypass acc_cmd_rs1", acc_if.cmd_rs1, 64'h5a);
        @(negedge clock);
        core_if.cmd_valid = 1'b0;
        #1;
        check("bypass not stored", 64'(acc_if.cmd_valid), 64'd0);
        check("bypass busy", 64'(busy), 64'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
